// File: rtl/uart_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_if
// Bundles the receiver-side handshake and the CPU-side FIFO/status bus of the
// UART receive drain controller.
//
//   Receiver side : r_ready, rx_data, rx_perr, rx_ferr (to controller)
//                   rdn (read strobe from controller, active low)
//   CPU side      : cpu_rd, stat_clr (to controller)
//                   cpu_data, cpu_perr, cpu_ferr, empty, full, count,
//                   overrun, err_cnt (from controller)
//
// master : the drain controller itself
// slave  : the environment (receiver + CPU bus)
// -----------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
   parameter int DEPTH_LOG2 = 3
);
   logic                  r_ready;
   logic [7:0]            rx_data;
   logic                  rx_perr;
   logic                  rx_ferr;
   logic                  rdn;
   logic                  cpu_rd;
   logic [7:0]            cpu_data;
   logic                  cpu_perr;
   logic                  cpu_ferr;
   logic                  empty;
   logic                  full;
   logic [DEPTH_LOG2:0]   count;
   logic                  overrun;
   logic [7:0]            err_cnt;
   logic                  stat_clr;

   modport master (
      input  r_ready, rx_data, rx_perr, rx_ferr, cpu_rd, stat_clr,
      output rdn, cpu_data, cpu_perr, cpu_ferr, empty, full, count,
             overrun, err_cnt
   );

   modport slave (
      output r_ready, rx_data, rx_perr, rx_ferr, cpu_rd, stat_clr,
      input  rdn, cpu_data, cpu_perr, cpu_ferr, empty, full, count,
             overrun, err_cnt
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Drain controller for the UART receiver. Whenever the receiver raises
// r_ready the controller strobes rdn low for one clk16x cycle, captures the
// byte plus its parity/frame status, and pushes {ferr,perr,data} into a
// first-word-fall-through FIFO popped by the CPU. Overrun (frame lost to a
// full FIFO) and a saturating errored-frame count are kept as statistics.
//
// Ports:
//   clk16x  : block clock, shared with the receiver
//   clrn    : synchronous active-low reset
//   bus     : uart_rx_ctrl_if.master
//             receiver side  r_ready/rx_data/rx_perr/rx_ferr in, rdn out
//             CPU side       cpu_rd/stat_clr in; cpu_data/cpu_perr/cpu_ferr,
//                            empty/full/count, overrun/err_cnt out
//
// Parameters:
//   DEPTH_LOG2 : log2 of FIFO depth
//   DROP_ERR   : 1 = errored frames are counted but never enter the FIFO
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
   parameter int DEPTH_LOG2 = 3,
   parameter bit DROP_ERR   = 1'b0
) (
   input  logic           clk16x,
   input  logic           clrn,
   uart_rx_ctrl_if.master bus
);

   localparam int                    DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STROBE   = 2'd1,
      PUSH     = 2'd2,
      WAIT_CLR = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    rdn_q, rdn_d;

   // Captured frame (data path, not reset)
   logic                    perr_q, perr_d;
   logic                    ferr_q, ferr_d;
   logic [7:0]              data_q, data_d;

   // FIFO control
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic [9:0]              head_q, head_d;
   logic [9:0]              mem_q [DEPTH];

   // Statistics
   logic                    overrun_q, overrun_d;
   logic [7:0]              err_q, err_d;

   logic                    frame_done;
   logic                    errored;
   logic                    push;
   logic                    pop;
   logic [9:0]              wr_word;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // ---------------------------------------------------------------------
   // FSM: next state, rdn and frame capture
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      rdn_d      = 1'b1;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      data_d     = data_q;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            // Status flags are taken here: the receiver clears them as soon
            // as it sees rdn low, while the byte itself stays valid.
            if (bus.r_ready) begin
               perr_d  = bus.rx_perr;
               ferr_d  = bus.rx_ferr;
               rdn_d   = 1'b0;
               state_d = STROBE;
            end
         end
         STROBE: begin
            data_d  = bus.rx_data;
            state_d = PUSH;
         end
         PUSH: begin
            frame_done = 1'b1;
            state_d    = WAIT_CLR;
         end
         WAIT_CLR: begin
            // Guard against re-reading a byte whose r_ready is still high.
            if (!bus.r_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FIFO push/pop, statistics and head-of-queue tracking
   // ---------------------------------------------------------------------
   always_comb begin
      errored   = perr_q | ferr_q;
      wr_word   = {ferr_q, perr_q, data_q};
      pop       = bus.cpu_rd && (count_q != '0);
      push      = 1'b0;

      // Clear first so that a same-cycle event below overrides it.
      overrun_d = bus.stat_clr ? 1'b0 : overrun_q;
      err_d     = bus.stat_clr ? 8'd0 : err_q;

      if (frame_done) begin
         if (errored) begin
            err_d = sat_inc8(err_d);
         end
         if (!(DROP_ERR && errored)) begin
            // A pop in the same cycle frees the slot being written.
            if ((count_q != FULL_CNT) || pop) begin
               push = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
         end
      end

      wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
         count_d = count_q - CNT_ONE;
      end

      // Registered head: holds its last value while the FIFO is empty. When
      // the word being written this cycle becomes the new head (push into an
      // empty FIFO, or push+pop with one entry) it bypasses the memory.
      head_d = head_q;
      if (count_d != '0) begin
         if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = wr_word;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Control registers (reset)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk16x) begin
      if (!clrn) begin
         state_q   <= IDLE;
         rdn_q     <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         head_q    <= '0;
         overrun_q <= 1'b0;
         err_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         rdn_q     <= rdn_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         head_q    <= head_d;
         overrun_q <= overrun_d;
         err_q     <= err_d;
      end
   end

   // ---------------------------------------------------------------------
   // Data registers and FIFO storage (no reset)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk16x) begin
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      data_q <= data_d;
      if (push && clrn) begin
         mem_q[wr_ptr_q] <= wr_word;
      end
   end

   assign bus.rdn      = rdn_q;
   assign bus.cpu_data = head_q[7:0];
   assign bus.cpu_perr = head_q[8];
   assign bus.cpu_ferr = head_q[9];
   assign bus.empty    = (count_q == '0);
   assign bus.full     = (count_q == FULL_CNT);
   assign bus.count    = count_q;
   assign bus.overrun  = overrun_q;
   assign bus.err_cnt  = err_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Drain controller for the UART receiver. It watches r_ready and strobes rdn low for one cycle to read each received byte together with its parity/frame status. Each result goes into a first-word-fall-through FIFO that the CPU pops. The block sits between the receiver and the CPU I/O bus, and tracks overrun and error statistics.

Parameters:
DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries)
DROP_ERR, 0, when 1 frames with parity or frame error are counted but not pushed

Ports:
clk16x  input  1  block clock (same clock as receiver)
clrn  input  1  synchronous active-low reset
r_ready  input  1  receiver byte-ready flag
rx_data  input  8  receiver d_out, valid only while rdn=0
rx_perr  input  1  receiver parity_error
rx_ferr  input  1  receiver frame_error
rdn  output  1  read strobe to receiver, active low, registered
cpu_rd  input  1  pop request, one pop per cycle high
cpu_data  output  8  FIFO head byte
cpu_perr  output  1  FIFO head parity-error flag
cpu_ferr  output  1  FIFO head frame-error flag
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  DEPTH_LOG2+1  FIFO occupancy
overrun  output  1  sticky: a frame was lost because the FIFO was full
err_cnt  output  8  saturating count of errored frames
stat_clr  input  1  clears overrun and err_cnt

Behaviour:
- Reset: clock is clk16x. Reset is synchronous and active-low on clrn, sampled on the clk16x edge. Reset values: rdn=1, empty=1, full=0, count=0, overrun=0, err_cnt=0, cpu_data/cpu_perr/cpu_ferr=0. FSM returns to IDLE. FIFO pointers are zeroed and contents are discarded.
- FSM states: IDLE, STROBE, PUSH, WAIT_CLR.
- IDLE: when r_ready=1 at edge k:
  - latch rx_perr and rx_ferr into status regs;
  - go to STROBE;
  - drive rdn=0 from edge k.
  - Flags must be captured here, because the receiver clears them while rdn=0.
- STROBE: at edge k+1:
  - latch rx_data;
  - rdn=1;
  - go to PUSH.
  - rdn is low for exactly one clk16x cycle.
- PUSH: at edge k+2, one of the following:
  - If status is errored (perr|ferr), increment err_cnt, saturating at 255.
  - If DROP_ERR=1 and the frame is errored, do not write the FIFO.
  - Otherwise, if the FIFO is not full, or is full with cpu_rd=1 in the same cycle, write {ferr,perr,data}.
  - Otherwise (full, no pop), drop the frame and set overrun.
  - Then go to WAIT_CLR.
- WAIT_CLR: stay until r_ready=0, then go to IDLE. This prevents a double read of the same byte.
- Latency: r_ready rising to empty falling (previously empty FIFO) is 3 edges.
- FIFO is first-word-fall-through. cpu_data/cpu_perr/cpu_ferr show the head whenever empty=0. The head value is undefined-but-stable when empty=1 (hold last).
- cpu_rd=1 with empty=0 pops at the edge. cpu_rd with empty=1 is ignored; count stays 0.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal at full and, for the push side, at empty (new data becomes head next cycle).
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. count saturates by construction at 2^DEPTH_LOG2; full = (count == 2^DEPTH_LOG2).
- stat_clr=1 clears overrun and err_cnt at the edge. If a set/increment event occurs in the same cycle, the event wins: overrun=1, err_cnt=1.
- Reset mid-sequence (any state): the abort is clean. If r_ready is still high after reset, that byte is read normally, with flags resampled in IDLE.
- Bytes received while FSM is busy are not lost by this block; receiver r_ready holds until strobed.

Test Plan:
- Single frame 0xA5, no errors: r_ready pulse -> rdn low exactly 1 cycle; 3 edges later empty=0, cpu_data=0xA5, perr=ferr=0, count=1; cpu_rd -> empty=1.
- Parity error frame 0x3C, DROP_ERR=0: rx_perr=1 with r_ready -> cpu_perr=1 at head, err_cnt=1. Repeat with DROP_ERR=1 -> FIFO stays empty, err_cnt=1.
- Fill 8 bytes 0x00..0x07 without popping -> full=1, count=8. 9th byte 0xFF -> overrun=1, count=8. Pops return 0x00..0x07 in order, then empty=1.
- Full FIFO with cpu_rd asserted in the PUSH cycle of byte 0x55 -> count stays 8, no overrun, 0x55 read as the last entry.
- r_ready held high for 20 cycles -> only one rdn strobe and one FIFO write. Pop while empty -> count stays 0.
- clrn low during STROBE with 3 entries queued -> next cycle count=0, empty=1, rdn=1, overrun=0, err_cnt=0. Also stat_clr coinciding with an errored PUSH -> err_cnt=1.
